// File: rtl/ex_mem_dmem_stage.sv
// EX->MEM boundary stage: captures the EX bundle, runs the data-memory req/ack transaction
// for loads/stores, stalls upstream while a request is pending, and delivers a registered,
// valid-qualified result toward MEM/WB.
// Optional feature macro: EX_MEM_TIMEOUT_EN adds a WAIT-cycle watchdog that aborts a hung access.
module ex_mem_dmem_stage #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned REG_AW         = 5,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              valid_ex,
    input  logic              flush,
    input  logic [1:0]        WB_ex,
    input  logic [1:0]        Mem_ex,
    input  logic [XLEN-1:0]   ALUResult_ex,
    input  logic [XLEN-1:0]   rs2Data_ex,
    input  logic [REG_AW-1:0] rdAddr_ex,
    output logic              stall_out,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_ack,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              valid_mem,
    output logic [1:0]        WB_mem,
    output logic [XLEN-1:0]   ALUResult_mem,
    output logic [XLEN-1:0]   MemData_mem,
    output logic [REG_AW-1:0] rdAddr_mem,
    output logic              err_timeout
);

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e            state_q;
    logic              valid_q;
    logic [1:0]        wb_q;     // {MemtoReg, RegWrite}
    logic [1:0]        mem_q;    // {MemRead, MemWrite}
    logic [XLEN-1:0]   alu_q;
    logic [XLEN-1:0]   rs2_q;
    logic [REG_AW-1:0] rd_q;

    logic in_wait;
    logic memop_q;
    logic load_q;
    logic capture_memop;
    logic done;
    logic abort;

    assign in_wait       = (state_q == StWait);
    assign memop_q       = valid_q & (mem_q[1] | mem_q[0]);
    // Read+write together behaves as a write, so only a pure read returns data.
    assign load_q        = mem_q[1] & ~mem_q[0];
    assign capture_memop = valid_ex & ~flush & (Mem_ex[1] | Mem_ex[0]);
    assign stall_out     = in_wait & ~dmem_ack;
    assign done          = (~in_wait & valid_q & ~memop_q) | (in_wait & dmem_ack);

    assign dmem_req   = in_wait;
    assign dmem_we    = mem_q[0];
    assign dmem_addr  = alu_q;
    assign dmem_wdata = rs2_q;

`ifdef EX_MEM_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q;

    assign abort = in_wait & ~dmem_ack & (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    // Watchdog: restarts whenever the stage advances, counts ack-less WAIT cycles.
    always_ff @(posedge clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else if (!stall_out || abort) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    // One-cycle abort indication.
    always_ff @(posedge clk) begin
        if (Reset) begin
            err_timeout <= 1'b0;
        end else begin
            err_timeout <= abort;
        end
    end
`else
    logic unused_timeout;

    assign abort          = 1'b0;
    assign err_timeout    = 1'b0;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Stage registers and IDLE/WAIT control; frozen while a request is pending.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            wb_q    <= '0;
            mem_q   <= '0;
            alu_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
        end else if (!stall_out) begin
            state_q <= capture_memop ? StWait : StIdle;
            valid_q <= valid_ex & ~flush;
            wb_q    <= WB_ex;
            mem_q   <= Mem_ex;
            alu_q   <= ALUResult_ex;
            rs2_q   <= rs2Data_ex;
            rd_q    <= rdAddr_ex;
        end else if (abort) begin
            // Upstream is still held this cycle; the aborted op is retired below.
            state_q <= StIdle;
            valid_q <= 1'b0;
        end
    end

    // Result registers toward MEM/WB; bundle holds its last value between pulses.
    always_ff @(posedge clk) begin
        if (Reset) begin
            valid_mem     <= 1'b0;
            WB_mem        <= '0;
            ALUResult_mem <= '0;
            MemData_mem   <= '0;
            rdAddr_mem    <= '0;
        end else begin
            valid_mem <= done | abort;
            if (done) begin
                WB_mem        <= wb_q;
                ALUResult_mem <= alu_q;
                MemData_mem   <= (in_wait && load_q) ? dmem_rdata : '0;
                rdAddr_mem    <= rd_q;
            end else if (abort) begin
                WB_mem        <= {wb_q[1], 1'b0};
                ALUResult_mem <= alu_q;
                MemData_mem   <= '0;
                rdAddr_mem    <= rd_q;
            end
        end
    end

endmodule
